multi_timer: RTL

- Parametrised multi-channel programmable timer; next generation of the single-channel periodic pulse timer.
- Provides CHANNELS independent counters behind one shared clock prescaler.
- Each channel runs in periodic or one-shot mode, with its own limit and start/stop control.
- Each channel raises a one-cycle pulse and a sticky interrupt flag; the processor clears the flag with an acknowledge.

---
 rtl/multi_timer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent programmable timers behind one shared prescaler.
// Each channel runs periodic or one-shot, raises a one-cycle pulse and a sticky irq.
// Optional: define TIMER_OVERRUN_EN to add the per-channel overrun flag output.
module multi_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [WIDTH-1:0]    wr_limit,
    input  logic                wr_mode,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] irq,
`ifdef TIMER_OVERRUN_EN
    output logic [CHANNELS-1:0] overrun,
`endif
    output logic [CHANNELS-1:0] running
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PW-1:0]  PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    logic [PW-1:0]       presc_q;
    logic                tick;
    logic [CW-1:0]       wr_idx;
    logic                wr_hit;
    state_e              state_q [CHANNELS];
    logic [WIDTH-1:0]    limit_q [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] irq_q;
    logic [CHANNELS-1:0] ovr_q;
    logic [CHANNELS-1:0] expire;

    // Only the low CW bits of wr_ch select a channel; out-of-range indices are dropped.
    if (CW < 3) begin : g_unused_wr_ch
        logic unused_wr_ch;
        assign unused_wr_ch = ^wr_ch[2:CW];
    end

    assign wr_idx = wr_ch[CW-1:0];
    assign wr_hit = wr_en && (32'(wr_idx) < CHANNELS);
    assign tick   = (presc_q == PRESCALE_LAST);

    // Expiry compare is widened by one bit so limit = 2^WIDTH-1 cannot wrap.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            expire[i] = tick && (limit_q[i] != '0) &&
                        (({1'b0, count_q[i]} + ONE) >= {1'b0, limit_q[i]});
        end
    end

    // Prescaler plus per-channel state machine, counters, config and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            mode_q  <= '0;
            pulse_q <= '0;
            irq_q   <= '0;
            ovr_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                limit_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                pulse_q[i] <= 1'b0;
                if (wr_hit && (wr_idx == CW'(i))) begin
                    limit_q[i] <= wr_limit;
                    mode_q[i]  <= wr_mode;
                end
                // Ack clears first so a same-cycle expiry below wins.
                if (ack[i]) begin
                    irq_q[i] <= 1'b0;
                    ovr_q[i] <= 1'b0;
                end
                case (state_q[i])
                    StIdle: begin
                        if (start[i] && !stop[i]) begin
                            state_q[i] <= StRun;
                            count_q[i] <= '0;
                        end
                    end
                    StRun: begin
                        if (stop[i]) begin
                            state_q[i] <= StIdle;
                        end else if (start[i]) begin
                            count_q[i] <= '0;
                        end else if (expire[i]) begin
                            pulse_q[i] <= 1'b1;
                            irq_q[i]   <= 1'b1;
                            count_q[i] <= '0;
                            if (irq_q[i]) begin
                                ovr_q[i] <= 1'b1;
                            end
                            if (mode_q[i]) begin
                                state_q[i] <= StIdle;
                            end
                        end else if (tick && (limit_q[i] != '0)) begin
                            count_q[i] <= count_q[i] + 1'b1;
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

    // Status and flag outputs straight from state registers.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            running[i] = (state_q[i] == StRun);
        end
    end

    assign pulse = pulse_q;
    assign irq   = irq_q;
`ifdef TIMER_OVERRUN_EN
    assign overrun = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = ^ovr_q;
`endif

endmodule
